// File: rtl/systolic_pkg.sv
// ----------------------------------------------------------------------------
// systolic_pkg
//   Shared types, default sizing and arithmetic helpers for the systolic PE.
//   - pe_state_e : PE tile ownership state (IDLE, ACC, DRAIN_WAIT)
//   - DEF_*      : default DATA_W / ACC_W / MUL_STAGES
//   - sat_add    : width-generic saturating signed add. Operands are passed
//                  sign-extended to SAT_W bits, the live width as argument w.
//                  Returns {overflow, clamped_sum[SAT_W-1:0]}.
// ----------------------------------------------------------------------------
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ACC        = 2'd1,
      DRAIN_WAIT = 2'd2
   } pe_state_e;

   localparam int DEF_DATA_W     = 16;
   localparam int DEF_ACC_W      = 40;
   localparam int DEF_MUL_STAGES = 2;

   // Widest accumulator sat_add can handle.
   localparam int SAT_W = 128;

   function automatic logic [SAT_W:0] sat_add(
      input logic signed [SAT_W-1:0] x,
      input logic signed [SAT_W-1:0] y,
      input int unsigned             w
   );
      logic signed [SAT_W:0] s;
      logic signed [SAT_W:0] mx;
      logic signed [SAT_W:0] mn;
      logic                  o;
      // One extra bit so the true sum never wraps before clamping.
      s  = $signed({x[SAT_W-1], x}) + $signed({y[SAT_W-1], y});
      mx = $signed(((SAT_W+1)'(1) << (w - 1)) - (SAT_W+1)'(1));
      mn = ~mx;  // -(2^(w-1))
      o  = 1'b0;
      if (s > mx) begin
         s = mx;
         o = 1'b1;
      end else if (s < mn) begin
         s = mn;
         o = 1'b1;
      end
      return {o, s[SAT_W-1:0]};
   endfunction

endpackage

// File: rtl/pe_mul_pipe.sv
// ----------------------------------------------------------------------------
// pe_mul_pipe
//   Signed DATA_W x DATA_W multiplier with a MUL_STAGES-deep register pipe
//   carrying the sign-extended product, a valid bit and the tile-start (clr)
//   tag. A product captured on the fire edge is presented on ret_* after
//   MUL_STAGES-1 further edges, so it retires MUL_STAGES edges after firing.
// Ports
//   clk, rst        clock, async active-low reset
//   fire, clr       launch a product / tag it as tile start
//   a, b            signed operands
//   ret_vld/clr/prod  retiring product (last pipe stage)
//   pipe_busy       any stage holds a valid product
// ----------------------------------------------------------------------------
module pe_mul_pipe
   import systolic_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ACC_W      = DEF_ACC_W,
   parameter int MUL_STAGES = DEF_MUL_STAGES
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fire,
   input  logic                     clr,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic                     ret_vld,
   output logic                     ret_clr,
   output logic signed [ACC_W-1:0]  ret_prod,
   output logic                     pipe_busy
);

   logic [MUL_STAGES-1:0]            vld_q, vld_d;
   logic [MUL_STAGES-1:0]            clr_q, clr_d;
   logic [MUL_STAGES-1:0][ACC_W-1:0] prod_q, prod_d;
   logic signed [2*DATA_W-1:0]       mult;

   always_comb begin
      mult      = a * b;
      vld_d     = '0;
      clr_d     = '0;
      prod_d    = '0;
      vld_d[0]  = fire;
      clr_d[0]  = fire & clr;
      // Zero idle slots to keep the pipe quiet between fires.
      prod_d[0] = fire ? ACC_W'(mult) : '0;
      for (int i = 1; i < MUL_STAGES; i++) begin
         vld_d[i]  = vld_q[i-1];
         clr_d[i]  = clr_q[i-1];
         prod_d[i] = prod_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q  <= '0;
         clr_q  <= '0;
         prod_q <= '0;
      end else begin
         vld_q  <= vld_d;
         clr_q  <= clr_d;
         prod_q <= prod_d;
      end
   end

   assign ret_vld   = vld_q[MUL_STAGES-1];
   assign ret_clr   = clr_q[MUL_STAGES-1];
   assign ret_prod  = $signed(prod_q[MUL_STAGES-1]);
   assign pipe_busy = |vld_q;

endmodule

// File: rtl/systolic_pe_mac.sv
// ----------------------------------------------------------------------------
// systolic_pe_mac
//   Output-stationary systolic PE: signed MAC with registered east/south
//   operand forwarding, pipelined multiplier and a partial-sum drain chain.
//   Optional macro PE_SAT_EN: saturating accumulate with sticky ovf;
//   without it the accumulator wraps and ovf is tied 0.
// Ports
//   clk, rst                   clock, async active-low reset
//   a_in/a_vld_in, b_in/b_vld_in  west / north operand + valid
//   clr                        tile-start tag, used only on a fire
//   drain                      request emission of the accumulator
//   psum_in/psum_vld_in        partial sum from the PE above
//   a_out/a_vld_out, b_out/b_vld_out  1-cycle east / south forward
//   psum_out/psum_vld_out      partial sum to the PE below (registered)
//   busy                       products in flight or drain pending
//   ovf, err                   sticky saturation / chain-collision flags
// ----------------------------------------------------------------------------
module systolic_pe_mac
   import systolic_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ACC_W      = DEF_ACC_W,
   parameter int MUL_STAGES = DEF_MUL_STAGES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] a_in,
   input  logic              a_vld_in,
   input  logic [DATA_W-1:0] b_in,
   input  logic              b_vld_in,
   input  logic              clr,
   input  logic              drain,
   input  logic [ACC_W-1:0]  psum_in,
   input  logic              psum_vld_in,
   output logic [DATA_W-1:0] a_out,
   output logic              a_vld_out,
   output logic [DATA_W-1:0] b_out,
   output logic              b_vld_out,
   output logic [ACC_W-1:0]  psum_out,
   output logic              psum_vld_out,
   output logic              busy,
   output logic              ovf,
   output logic              err
);

   if (ACC_W < 2*DATA_W) begin : g_acc_w_chk
      $error("systolic_pe_mac: ACC_W must be >= 2*DATA_W");
   end
   if (MUL_STAGES < 1 || MUL_STAGES > 3) begin : g_stages_chk
      $error("systolic_pe_mac: MUL_STAGES must be 1..3");
   end
   if (ACC_W > SAT_W) begin : g_sat_w_chk
      $error("systolic_pe_mac: ACC_W exceeds sat_add width");
   end

   logic                    fire;
   logic                    ret_vld, ret_clr, pipe_busy;
   logic signed [ACC_W-1:0] ret_prod;

   logic [DATA_W-1:0]       a_q, b_q;
   logic                    a_vld_q, b_vld_q;
   logic [ACC_W-1:0]        psum_q, psum_d;
   logic                    psum_vld_q, psum_vld_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   pe_state_e               state_q, state_d;
   logic                    err_q, err_d;
   logic                    emit;
`ifdef PE_SAT_EN
   logic                    ovf_q, ovf_d;
   logic [SAT_W:0]          sat_res;
`endif

   assign fire = a_vld_in & b_vld_in;

   pe_mul_pipe #(
      .DATA_W     (DATA_W),
      .ACC_W      (ACC_W),
      .MUL_STAGES (MUL_STAGES)
   ) u_mul (
      .clk       (clk),
      .rst       (rst),
      .fire      (fire),
      .clr       (clr),
      .a         ($signed(a_in)),
      .b         ($signed(b_in)),
      .ret_vld   (ret_vld),
      .ret_clr   (ret_clr),
      .ret_prod  (ret_prod),
      .pipe_busy (pipe_busy)
   );

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      err_d      = err_q;
      emit       = 1'b0;
      psum_d     = psum_in;
      psum_vld_d = psum_vld_in;
`ifdef PE_SAT_EN
      ovf_d      = ovf_q;
      sat_res    = sat_add(SAT_W'(acc_q), SAT_W'(ret_prod), ACC_W);
`endif

      if (ret_vld) begin
         if (ret_clr) begin
            acc_d = ret_prod;
         end else begin
`ifdef PE_SAT_EN
            acc_d = $signed(sat_res[ACC_W-1:0]);
            ovf_d = ovf_q | sat_res[SAT_W];
`else
            acc_d = acc_q + ret_prod;
`endif
         end
         if (state_q == IDLE) state_d = ACC;
      end

      // Emission only happens with the pipe empty, so it never races a retire.
      unique case (state_q)
         IDLE, ACC: begin
            if (drain) begin
               if (pipe_busy) state_d = DRAIN_WAIT;
               else           emit    = 1'b1;
            end
         end
         DRAIN_WAIT: begin
            if (!pipe_busy) emit = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (emit) begin
         psum_d     = acc_q;
         psum_vld_d = 1'b1;
         acc_d      = '0;
         state_d    = IDLE;
         // Local word wins the chain slot; the incoming one is lost.
         if (psum_vld_in) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q        <= '0;
         a_vld_q    <= 1'b0;
         b_q        <= '0;
         b_vld_q    <= 1'b0;
         psum_q     <= '0;
         psum_vld_q <= 1'b0;
         acc_q      <= '0;
         state_q    <= IDLE;
         err_q      <= 1'b0;
`ifdef PE_SAT_EN
         ovf_q      <= 1'b0;
`endif
      end else begin
         a_q        <= a_in;
         a_vld_q    <= a_vld_in;
         b_q        <= b_in;
         b_vld_q    <= b_vld_in;
         psum_q     <= psum_d;
         psum_vld_q <= psum_vld_d;
         acc_q      <= acc_d;
         state_q    <= state_d;
         err_q      <= err_d;
`ifdef PE_SAT_EN
         ovf_q      <= ovf_d;
`endif
      end
   end

   assign a_out        = a_q;
   assign a_vld_out    = a_vld_q;
   assign b_out        = b_q;
   assign b_vld_out    = b_vld_q;
   assign psum_out     = psum_q;
   assign psum_vld_out = psum_vld_q;
   assign busy         = pipe_busy | (state_q == DRAIN_WAIT);
   assign err          = err_q;
`ifdef PE_SAT_EN
   assign ovf          = ovf_q;
`else
   assign ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_pe_mac.sv
// ----------------------------------------------------------------------------
// tb_systolic_pe_mac
//   Directed scenarios for systolic_pe_mac (DATA_W=16, ACC_W=40, MUL_STAGES=2).
//   Every expected psum word is queued when its cause is driven and checked
//   by a monitor whenever psum_vld_out is seen; timing, flags and forwarding
//   are checked inline in each scenario task.
// ----------------------------------------------------------------------------
module tb_systolic_pe_mac;

   localparam int DATA_W     = 16;
   localparam int ACC_W      = 40;
   localparam int MUL_STAGES = 2;

`ifdef PE_SAT_EN
   localparam logic [ACC_W-1:0] OVF_EXP_PSUM = 40'h7F_FFFF_FFFF;
   localparam logic             OVF_EXP_FLAG = 1'b1;
`else
   localparam logic [ACC_W-1:0] OVF_EXP_PSUM = 40'h80_0000_0000;
   localparam logic             OVF_EXP_FLAG = 1'b0;
`endif

   logic              clk, rst;
   logic [DATA_W-1:0] a_in, b_in, a_out, b_out;
   logic              a_vld_in, b_vld_in, a_vld_out, b_vld_out;
   logic              clr, drain;
   logic [ACC_W-1:0]  psum_in, psum_out;
   logic              psum_vld_in, psum_vld_out;
   logic              busy, ovf, err;

   int checks = 0;
   int errors = 0;
   logic [ACC_W-1:0] exp_q[$];
   logic [ACC_W-1:0] mon_exp;

   systolic_pe_mac #(
      .DATA_W     (DATA_W),
      .ACC_W      (ACC_W),
      .MUL_STAGES (MUL_STAGES)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .a_in         (a_in),
      .a_vld_in     (a_vld_in),
      .b_in         (b_in),
      .b_vld_in     (b_vld_in),
      .clr          (clr),
      .drain        (drain),
      .psum_in      (psum_in),
      .psum_vld_in  (psum_vld_in),
      .a_out        (a_out),
      .a_vld_out    (a_vld_out),
      .b_out        (b_out),
      .b_vld_out    (b_vld_out),
      .psum_out     (psum_out),
      .psum_vld_out (psum_vld_out),
      .busy         (busy),
      .ovf          (ovf),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every psum word on the chain must match the oldest expectation.
   always @(negedge clk) begin
      if (rst && psum_vld_out) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL psum_unexpected got %0d expected none", $signed(psum_out));
         end else begin
            mon_exp = exp_q.pop_front();
            if (psum_out !== mon_exp) begin
               errors++;
               $display("FAIL psum_value got %0d expected %0d", $signed(psum_out), $signed(mon_exp));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      a_vld_in    = 1'b0;
      b_vld_in    = 1'b0;
      clr         = 1'b0;
      drain       = 1'b0;
      psum_vld_in = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      a_in = '0; b_in = '0; psum_in = '0;
      rst = 1'b0;
      tick(); tick();
      checks++;
      if ({psum_vld_out, busy, ovf, err, a_vld_out, b_vld_out} !== 6'b0 || psum_out !== '0) begin
         errors++;
         $display("FAIL reset_state got vld=%b busy=%b ovf=%b err=%b psum=%0d expected all 0",
                  psum_vld_out, busy, ovf, err, psum_out);
      end
      rst = 1'b1;
      tick();
      a_in = 16'd5; b_in = 16'd5; a_vld_in = 1'b1; b_vld_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         clr = (i == 0);
         tick();
      end
      checks++;
      if (busy !== 1'b1 || a_vld_out !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_busy got busy=%b a_vld_out=%b expected 1 1", busy, a_vld_out);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || a_vld_out !== 1'b0 || b_vld_out !== 1'b0 || a_out !== '0 ||
          b_out !== '0 || psum_vld_out !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got busy=%b a_vld=%b b_vld=%b a=%0d b=%0d pvld=%b expected 0",
                  busy, a_vld_out, b_vld_out, a_out, b_out, psum_vld_out);
      end
      idle();
      #1;
      rst = 1'b1;
      tick();
      drain = 1'b1;
      exp_q.push_back('0);
      tick();
      drain = 1'b0;
      checks++;
      if (psum_vld_out !== 1'b1) begin
         errors++;
         $display("FAIL reset_drain_emit got psum_vld_out=%b expected 1", psum_vld_out);
      end
      tick();
   endtask

   task automatic test_mac();
      for (int i = 0; i < 4; i++) begin
         a_in = 16'd3; b_in = 16'd4; a_vld_in = 1'b1; b_vld_in = 1'b1;
         clr = (i == 0);
         tick();
         if (i == 0) begin
            checks++;
            if (a_out !== 16'd3 || a_vld_out !== 1'b1 || b_out !== 16'd4 || b_vld_out !== 1'b1) begin
               errors++;
               $display("FAIL mac_forward got a=%0d/%b b=%0d/%b expected 3/1 4/1",
                        a_out, a_vld_out, b_out, b_vld_out);
            end
         end
      end
      idle();
      drain = 1'b1;
      exp_q.push_back(40'd48);
      tick();
      drain = 1'b0;
      checks++;
      if (busy !== 1'b1 || psum_vld_out !== 1'b0) begin
         errors++;
         $display("FAIL mac_drain_wait got busy=%b pvld=%b expected 1 0", busy, psum_vld_out);
      end
      tick();
      checks++;
      if (busy !== 1'b1 || psum_vld_out !== 1'b0) begin
         errors++;
         $display("FAIL mac_last_retire got busy=%b pvld=%b expected 1 0", busy, psum_vld_out);
      end
      tick();
      checks++;
      if (psum_vld_out !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mac_emit got pvld=%b busy=%b expected 1 0", psum_vld_out, busy);
      end
      tick();
      checks++;
      if (psum_vld_out !== 1'b0) begin
         errors++;
         $display("FAIL mac_emit_once got pvld=%b expected 0", psum_vld_out);
      end
   endtask

   task automatic test_clr();
      for (int i = 0; i < 4; i++) begin
         a_in = 16'd3; b_in = 16'd4; a_vld_in = 1'b1; b_vld_in = 1'b1;
         clr = (i == 0);
         tick();
      end
      idle();
      tick(); tick(); tick();
      a_in = 16'd2; b_in = 16'd5; a_vld_in = 1'b1; b_vld_in = 1'b1; clr = 1'b1;
      tick();
      idle();
      drain = 1'b1;
      exp_q.push_back(40'd10);
      tick();
      drain = 1'b0;
      checks++;
      if (busy !== 1'b1 || psum_vld_out !== 1'b0) begin
         errors++;
         $display("FAIL clr_wait got busy=%b pvld=%b expected 1 0", busy, psum_vld_out);
      end
      tick();
      checks++;
      if (psum_vld_out !== 1'b0) begin
         errors++;
         $display("FAIL clr_retire got pvld=%b expected 0", psum_vld_out);
      end
      tick();
      checks++;
      if (psum_vld_out !== 1'b1) begin
         errors++;
         $display("FAIL clr_emit got pvld=%b expected 1", psum_vld_out);
      end
      // Untagged fire after an emit must start from a cleared accumulator.
      a_in = 16'd2; b_in = 16'd5; a_vld_in = 1'b1; b_vld_in = 1'b1; clr = 1'b0;
      tick();
      idle();
      tick(); tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL acc_settled got busy=%b expected 0", busy);
      end
      drain = 1'b1;
      exp_q.push_back(40'd10);
      tick();
      drain = 1'b0;
      checks++;
      if (psum_vld_out !== 1'b1) begin
         errors++;
         $display("FAIL acc_direct_emit got pvld=%b expected 1", psum_vld_out);
      end
      tick();
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 512; i++) begin
         a_in = 16'h8000; b_in = 16'h8000; a_vld_in = 1'b1; b_vld_in = 1'b1;
         clr = (i == 0);
         tick();
      end
      idle();
      tick(); tick(); tick();
      drain = 1'b1;
      exp_q.push_back(OVF_EXP_PSUM);
      tick();
      drain = 1'b0;
      checks++;
      if (psum_vld_out !== 1'b1) begin
         errors++;
         $display("FAIL ovf_emit got pvld=%b expected 1", psum_vld_out);
      end
      checks++;
      if (ovf !== OVF_EXP_FLAG) begin
         errors++;
         $display("FAIL ovf_flag got %b expected %b", ovf, OVF_EXP_FLAG);
      end
      tick();
      checks++;
      if (ovf !== OVF_EXP_FLAG) begin
         errors++;
         $display("FAIL ovf_sticky got %b expected %b", ovf, OVF_EXP_FLAG);
      end
   endtask

   task automatic test_chain();
      psum_in = 40'h123; psum_vld_in = 1'b1;
      exp_q.push_back(40'h123);
      tick();
      psum_vld_in = 1'b0;
      checks++;
      if (psum_vld_out !== 1'b1 || psum_out !== 40'h123 || err !== 1'b0) begin
         errors++;
         $display("FAIL chain_pass got pvld=%b psum=%0h err=%b expected 1 123 0",
                  psum_vld_out, psum_out, err);
      end
      tick();
      checks++;
      if (psum_vld_out !== 1'b0) begin
         errors++;
         $display("FAIL chain_idle got pvld=%b expected 0", psum_vld_out);
      end
      a_in = 16'd7; b_in = 16'd3; a_vld_in = 1'b1; b_vld_in = 1'b1; clr = 1'b1;
      tick();
      idle();
      tick(); tick();
      drain = 1'b1; psum_in = 40'h999; psum_vld_in = 1'b1;
      exp_q.push_back(40'd21);
      tick();
      idle();
      checks++;
      if (psum_vld_out !== 1'b1 || psum_out !== 40'd21) begin
         errors++;
         $display("FAIL collide_local got pvld=%b psum=%0d expected 1 21", psum_vld_out, psum_out);
      end
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL collide_err got %b expected 1", err);
      end
      tick();
      checks++;
      if (psum_vld_out !== 1'b0 || err !== 1'b1) begin
         errors++;
         $display("FAIL collide_drop got pvld=%b err=%b expected 0 1", psum_vld_out, err);
      end
   endtask

   task automatic test_mismatch();
      a_in = 16'd7; a_vld_in = 1'b1; b_in = 16'd9; b_vld_in = 1'b0;
      tick();
      idle();
      checks++;
      if (a_out !== 16'd7 || a_vld_out !== 1'b1 || b_vld_out !== 1'b0 || b_out !== 16'd9) begin
         errors++;
         $display("FAIL mismatch_fwd got a=%0d/%b b=%0d/%b expected 7/1 9/0",
                  a_out, a_vld_out, b_out, b_vld_out);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL mismatch_busy got %b expected 0", busy);
      end
      tick(); tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL mismatch_busy_late got %b expected 0", busy);
      end
      drain = 1'b1;
      exp_q.push_back('0);
      tick();
      drain = 1'b0;
      checks++;
      if (psum_vld_out !== 1'b1) begin
         errors++;
         $display("FAIL mismatch_emit got pvld=%b expected 1", psum_vld_out);
      end
      tick();
   endtask

   initial begin
      rst = 1'b0;
      idle();
      a_in = '0; b_in = '0; psum_in = '0;
      test_reset();
      test_mac();
      test_clr();
      test_overflow();
      test_chain();
      test_mismatch();
      tick(); tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
